// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - 8-way round-robin arbiter with hold-time limit
//
// Ports:
//   clk      in   1  clock, all state updates on the rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   8  request vector, req[i]=1 when requester i wants the resource
//   done     in   1  current grantee releases the resource this cycle
//   gnt      out  8  one-hot grant vector, zero when no grant is active
//   gnt_idx  out  3  binary index of the grantee, zero when gnt_vld=0
//   gnt_vld  out  1  high exactly when gnt is non-zero
//   timeout  out  1  one-cycle pulse after a grant revoked by the hold limit
module round_robin_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [3:0] cnt;
    logic [3:0] cnt_d;
    logic [2:0] last_idx;
    logic [2:0] last_idx_d;
    logic [7:0] gnt_d;
    logic [2:0] gnt_idx_d;
    logic       gnt_vld_d;
    logic       timeout_d;

    logic       found;
    logic [2:0] pick_idx;
    logic [2:0] cand;
    logic       hold_limit;
    logic       release_gnt;

    // Search starts one past the previous grantee; offset 8 wraps back onto
    // last_idx itself, so the previous grantee is considered last.
    always_comb begin
        found    = 1'b0;
        pick_idx = 3'd0;
        cand     = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = last_idx + 3'(k);
            if (!found && req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // cnt is 0 in the first grant cycle, so reaching TIMEOUT-1 means the grant
    // has been visible for TIMEOUT cycles.
    assign hold_limit  = (cnt == 4'(TIMEOUT - 1));
    assign release_gnt = done || !req[gnt_idx] || hold_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            last_idx <= 3'd7;
            gnt      <= 8'd0;
            gnt_idx  <= 3'd0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            last_idx <= last_idx_d;
            gnt      <= gnt_d;
            gnt_idx  <= gnt_idx_d;
            gnt_vld  <= gnt_vld_d;
            timeout  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (found)       state_d = GRANT;
            GRANT:   if (release_gnt) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = gnt;
        gnt_idx_d  = gnt_idx;
        gnt_vld_d  = gnt_vld;
        timeout_d  = 1'b0;
        cnt_d      = cnt;
        last_idx_d = last_idx;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_d     = 8'd1 << pick_idx;
                    gnt_idx_d = pick_idx;
                    gnt_vld_d = 1'b1;
                    cnt_d     = 4'd0;
                end else begin
                    gnt_d     = 8'd0;
                    gnt_idx_d = 3'd0;
                    gnt_vld_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_gnt) begin
                    gnt_d      = 8'd0;
                    gnt_idx_d  = 3'd0;
                    gnt_vld_d  = 1'b0;
                    cnt_d      = 4'd0;
                    last_idx_d = gnt_idx;
                    // Only a release forced purely by the hold limit is flagged.
                    timeout_d  = hold_limit && !done && req[gnt_idx];
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            default: begin
                gnt_d     = 8'd0;
                gnt_idx_d = 3'd0;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb/tb_round_robin_arbiter.sv - self-checking bench for round_robin_arbiter
module tb_round_robin_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;
    logic [7:0] g1;
    logic [2:0] g1_idx;
    logic       g1_vld;
    logic       g1_to;

    round_robin_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
    );

    round_robin_arbiter #(.TIMEOUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(g1), .gnt_idx(g1_idx), .gnt_vld(g1_vld), .timeout(g1_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per instance, who holds the grant and for how many cycles.
    int m_busy[2];
    int m_holder[2];
    int m_held[2];
    int m_last[2];
    int m_to[2];
    int m_lim[2] = '{15, 1};

    int wc[8];
    logic prev_vld;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m] = 0; m_holder[m] = 0; m_held[m] = 0; m_last[m] = 7; m_to[m] = 0;
        end
        for (int i = 0; i < 8; i++) wc[i] = 0;
        prev_vld = 1'b0;
    endtask

    task automatic model_step(input int m, input logic [7:0] r, input logic d);
        int c;
        int hit;
        if (m_busy[m] != 0) begin
            if (d || !r[m_holder[m]] || m_held[m] == m_lim[m]) begin
                m_to[m]   = (m_held[m] == m_lim[m] && !d && r[m_holder[m]]) ? 1 : 0;
                m_last[m] = m_holder[m];
                m_busy[m] = 0;
            end else begin
                m_to[m] = 0;
                m_held[m]++;
            end
        end else begin
            m_to[m] = 0;
            hit = 0;
            for (int off = 1; off <= 8; off++) begin
                c = (m_last[m] + off) % 8;
                if (hit == 0 && r[c]) begin
                    hit = 1;
                    m_holder[m] = c;
                    m_busy[m]   = 1;
                    m_held[m]   = 1;
                end
            end
        end
    endtask

    task automatic compare_models();
        logic [7:0] eg;
        eg = (m_busy[0] != 0) ? (8'd1 << m_holder[0]) : 8'd0;
        check("m0_gnt", gnt, eg);
        check("m0_idx", gnt_idx, (m_busy[0] != 0) ? m_holder[0] : 0);
        check("m0_vld", gnt_vld, m_busy[0]);
        check("m0_to", timeout, m_to[0]);
        eg = (m_busy[1] != 0) ? (8'd1 << m_holder[1]) : 8'd0;
        check("m1_gnt", g1, eg);
        check("m1_idx", g1_idx, (m_busy[1] != 0) ? m_holder[1] : 0);
        check("m1_vld", g1_vld, m_busy[1]);
        check("m1_to", g1_to, m_to[1]);
        check("onehot0", $onehot0(gnt), 1);
        check("onehot1", $onehot0(g1), 1);
        check("vld_nz", gnt_vld, (gnt != 8'd0));
    endtask

    // Counts grants given to others while requester i keeps asking.
    task automatic fairness(input logic [7:0] r);
        for (int i = 0; i < 8; i++)
            if (!r[i]) wc[i] = 0;
        if (gnt_vld && !prev_vld) begin
            for (int i = 0; i < 8; i++) begin
                if (r[i] && int'(gnt_idx) != i) wc[i]++;
                if (int'(gnt_idx) == i) wc[i] = 0;
            end
            for (int i = 0; i < 8; i++)
                if (wc[i] > 7) check("starve", wc[i], 7);
            check("starve_ok", (wc[0] <= 7 && wc[1] <= 7 && wc[2] <= 7 && wc[3] <= 7 &&
                                wc[4] <= 7 && wc[5] <= 7 && wc[6] <= 7 && wc[7] <= 7), 1);
        end
        prev_vld = gnt_vld;
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(0, r, d);
        model_step(1, r, d);
        @(negedge clk);
        compare_models();
        fairness(r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'd0;
        done  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_idx", gnt_idx, 0);
        check("rst_vld", gnt_vld, 0);
        check("rst_to", timeout, 0);
        check("rst_gnt1", g1, 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] r;
        logic       d;
        logic       vld;
        logic [2:0] idx;
        logic       to;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [7:0] rr;
        logic [7:0] eg;

        tbl[0]  = '{8'hA4, 1'b0, 1'b1, 3'd2, 1'b0};
        tbl[1]  = '{8'hA4, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{8'hA4, 1'b0, 1'b1, 3'd5, 1'b0};
        tbl[3]  = '{8'hA4, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[4]  = '{8'hA4, 1'b0, 1'b1, 3'd7, 1'b0};
        tbl[5]  = '{8'hA4, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[6]  = '{8'hA4, 1'b0, 1'b1, 3'd2, 1'b0};
        tbl[7]  = '{8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[9]  = '{8'h08, 1'b0, 1'b1, 3'd3, 1'b0};
        tbl[10] = '{8'h18, 1'b0, 1'b1, 3'd3, 1'b0};
        tbl[11] = '{8'h10, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[12] = '{8'h19, 1'b0, 1'b1, 3'd4, 1'b0};
        tbl[13] = '{8'h19, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[14] = '{8'h09, 1'b0, 1'b1, 3'd0, 1'b0};

        do_reset();

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].r, tbl[i].d);
            eg = tbl[i].vld ? (8'd1 << tbl[i].idx) : 8'd0;
            check("tbl_gnt", gnt, eg);
            check("tbl_idx", gnt_idx, tbl[i].idx);
            check("tbl_vld", gnt_vld, tbl[i].vld);
            check("tbl_to", timeout, tbl[i].to);
        end

        // Sole requester held: 15-cycle grant, timeout pulse, re-grant.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(8'h01, 1'b0);
            check("hold_gnt", gnt, 8'h01);
            check("hold_to", timeout, 0);
            if (i == 0) check("t1_vld", g1_vld, 1);
            if (i == 1) begin
                check("t1_idle", g1_vld, 0);
                check("t1_to", g1_to, 1);
            end
        end
        cycle(8'h01, 1'b0);
        check("lim_vld", gnt_vld, 0);
        check("lim_to", timeout, 1);
        cycle(8'h01, 1'b0);
        check("regrant_gnt", gnt, 8'h01);
        check("regrant_to", timeout, 0);

        // done coincides with the hold limit.
        for (int i = 0; i < 14; i++) cycle(8'h01, 1'b0);
        check("pre_done_vld", gnt_vld, 1);
        cycle(8'h01, 1'b1);
        check("done_lim_vld", gnt_vld, 0);
        check("done_lim_to", timeout, 0);

        // req falls at the hold limit.
        cycle(8'h01, 1'b0);
        for (int i = 0; i < 14; i++) cycle(8'h01, 1'b0);
        cycle(8'h00, 1'b0);
        check("drop_lim_vld", gnt_vld, 0);
        check("drop_lim_to", timeout, 0);

        // Reset asserted while idx 6 holds the grant.
        cycle(8'h40, 1'b0);
        check("g6_idx", gnt_idx, 6);
        cycle(8'hFF, 1'b0);
        check("g6_hold", gnt_idx, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", gnt, 0);
        check("async_vld", gnt_vld, 0);
        check("async_to", timeout, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(8'hFF, 1'b0);
        check("post_rst_idx", gnt_idx, 0);
        check("post_rst_vld", gnt_vld, 1);

        // Random phase against the reference model.
        rr = 8'h00;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            cycle(rr, ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
